muldiv_unit: RTL

- Iterative 16-bit unsigned multiply/divide unit that feeds the dual-write-port register file directly.
- Accepts one operation at a time and runs 16 shift-add or restore-subtract iterations.
- Returns both results in one write cycle:
  - primary result (product low / quotient) to the destination register;
  - secondary result (product high / remainder) to R0.
- Sits beside the ALU in the execute stage. Its write outputs are muxed onto the register file's RegWrite/WriteReg/WriteData ports.

---
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit writing both results to the register file in one cycle.
// Build option: define MULDIV_DIV_EN to include the restoring divider; otherwise divide reports error.
module muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       dest_reg,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       RegWrite,
    output logic [3:0]       WriteReg1,
    output logic [3:0]       WriteReg2,
    output logic [WIDTH-1:0] WriteData1,
    output logic [WIDTH-1:0] WriteData2
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   b_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic [1:0]         regwrite_q;
    logic [3:0]         wreg1_q;
    logic [WIDTH-1:0]   wdata1_q;
    logic [WIDTH-1:0]   wdata2_q;
    logic [WIDTH:0]     mul_sum;

`ifdef MULDIV_DIV_EN
    logic               op_q;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
`endif

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_sub   = div_shift[WIDTH-1:0] - b_q;
        if (op_q) begin
            if (div_ge) begin
                acc_d = {div_sub, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            regwrite_q <= 2'd0;
            wreg1_q    <= 4'd0;
            wdata1_q   <= '0;
            wdata2_q   <= '0;
`ifdef MULDIV_DIV_EN
            op_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q     <= 1'b0;
                    error_q    <= 1'b0;
                    regwrite_q <= 2'd0;
                    if (start) begin
                        cnt_q   <= '0;
                        acc_q   <= {{WIDTH{1'b0}}, operand_a};
                        b_q     <= operand_b;
                        wreg1_q <= dest_reg;
                        busy_q  <= 1'b1;
`ifdef MULDIV_DIV_EN
                        op_q    <= op;
`endif
                        if (op) begin
`ifdef MULDIV_DIV_EN
                            if (operand_b == '0) begin
                                state_q    <= S_DONE;
                                done_q     <= 1'b1;
                                error_q    <= 1'b1;
                                wdata1_q   <= '1;
                                wdata2_q   <= operand_a;
                                regwrite_q <= (dest_reg == 4'd0) ? 2'd1 : 2'd2;
                            end else begin
                                state_q <= S_BUSY;
                            end
`else
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            error_q    <= 1'b1;
                            regwrite_q <= 2'd0;
`endif
                        end else begin
                            state_q <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        error_q    <= 1'b0;
                        wdata1_q   <= acc_d[WIDTH-1:0];
                        wdata2_q   <= acc_d[2*WIDTH-1:WIDTH];
                        // R0 as destination: only the primary result survives
                        regwrite_q <= (wreg1_q == 4'd0) ? 2'd1 : 2'd2;
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    error_q    <= 1'b0;
                    regwrite_q <= 2'd0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    error_q    <= 1'b0;
                    regwrite_q <= 2'd0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign RegWrite   = regwrite_q;
    assign WriteReg1  = wreg1_q;
    assign WriteReg2  = 4'd0;
    assign WriteData1 = wdata1_q;
    assign WriteData2 = wdata2_q;

endmodule
